// File: rtl/rv32_pkg.sv
// Shared RV32 types and load funct3 encodings used by the writeback slice.
package rv32_pkg;

  localparam int unsigned RV_XLEN = 32;

  typedef logic [4:0]         reg_addr_t;
  typedef logic [RV_XLEN-1:0] word_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/wb_writer_load_extend.sv
// Combinational load alignment and sign/zero extension for LB/LH/LW/LBU/LHU.
module load_extend
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;

  // Halfword lane uses only offset[1]; a misaligned low bit is ignored.
  always_comb begin
    byte_shift = data >> {offset, 3'b000};
    half_shift = data >> {offset[1], 4'b0000};
    byte_val   = byte_shift[7:0];
    half_val   = half_shift[15:0];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_val};
      F3_LH:   result = {{(XLEN-16){half_val[15]}}, half_val};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_val};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// Writeback unit: load-priority merge of ALU and load results into one registered
// regfile write per cycle. Optional decode bypass ports under `WB_BYPASS_EN.
module wb_writer
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_addr_t       alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  reg_addr_t       ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_data,
  output reg_addr_t       waddr,
  output logic [XLEN-1:0] wdata,
  output logic            regwen
`ifdef WB_BYPASS_EN
  ,
  input  reg_addr_t       addr1,
  input  reg_addr_t       addr2,
  output logic            byp1_hit,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp1_data,
  output logic [XLEN-1:0] byp2_data
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic            skid_full_q, skid_full_d;
  reg_addr_t       skid_rd_q,   skid_rd_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0] starve_q,   starve_d;
  logic            regwen_q,    regwen_d;
  reg_addr_t       waddr_q,     waddr_d;
  logic [XLEN-1:0] wdata_q,     wdata_d;

  logic [XLEN-1:0] ld_ext;
  logic            alu_cand_valid;
  reg_addr_t       alu_cand_rd;
  logic [XLEN-1:0] alu_cand_data;
  logic            force_alu;
  logic            ld_win;
  logic            alu_win;
  logic            alu_acc;
  reg_addr_t       win_rd;
  logic [XLEN-1:0] win_data;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (ld_funct3),
    .offset (ld_offset),
    .data   (ld_data),
    .result (ld_ext)
  );

  // A full skid blocks new ALU beats, so the skid entry is always the oldest ALU result.
  always_comb begin
    alu_cand_valid = skid_full_q | alu_valid;
    alu_cand_rd    = skid_full_q ? skid_rd_q   : alu_rd;
    alu_cand_data  = skid_full_q ? skid_data_q : alu_data;

    force_alu = alu_cand_valid & ld_valid & (starve_q == CNT_MAX);
    ld_win    = ld_valid & ~force_alu;
    alu_win   = alu_cand_valid & ~ld_win;

    alu_ready = rst & ~skid_full_q;
    ld_ready  = rst & ~force_alu;
    alu_acc   = alu_valid & alu_ready;

    win_rd   = ld_win ? ld_rd  : alu_cand_rd;
    win_data = ld_win ? ld_ext : alu_cand_data;
  end

  always_comb begin
    skid_full_d = skid_full_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    if (skid_full_q) begin
      if (alu_win) skid_full_d = 1'b0;
    end else if (alu_acc && !alu_win) begin
      skid_full_d = 1'b1;
      skid_rd_d   = alu_rd;
      skid_data_d = alu_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (alu_win) begin
      starve_d = '0;
    end else if (ld_win && alu_cand_valid && starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Writes to x0 are consumed but present as an idle cycle on the port.
  always_comb begin
    regwen_d = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    if ((ld_win || alu_win) && win_rd != '0) begin
      regwen_d = 1'b1;
      waddr_d  = win_rd;
      wdata_d  = win_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_full_q <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      starve_q    <= '0;
      regwen_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      starve_q    <= starve_d;
      regwen_q    <= regwen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign regwen = regwen_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;

`ifdef WB_BYPASS_EN
  always_comb begin
    byp1_hit  = regwen_q & (waddr_q == addr1) & (addr1 != '0);
    byp2_hit  = regwen_q & (waddr_q == addr2) & (addr2 != '0);
    byp1_data = wdata_q;
    byp2_data = wdata_q;
  end
`endif

endmodule
